// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding and the
// default memory depth in words.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEPTH_DEFAULT = 256;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin grant. The grant is combinational from the requests and
// the last_grant register; last_grant moves only when update is high and a
// grant is actually issued.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req0, req1   requests from port 0 / port 1
//   update       commit the current grant into last_grant
//   gnt0, gnt1   one-hot (or zero) grant
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt0,
  output logic gnt1
);

  // 0 = port 0 granted last, 1 = port 1 granted last
  logic last_grant;

  // On a tie the port that was not granted last wins.
  always_comb begin
    gnt0 = req0 & (~req1 | last_grant);
    gnt1 = req1 & (~req0 | ~last_grant);
  end

  // Resets to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update && (gnt0 || gnt1)) begin
      last_grant <= gnt1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates two requesters (p0 = pipeline MEM stage, p1 = loader/debug) onto a
// single external data memory. Each transaction takes IDLE -> ACCESS -> RESP;
// out-of-range addresses skip ACCESS and answer with err in RESP.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   pX_req/we/addr/wdata           request interface of port X (held until ack/err)
//   pX_ack, pX_err                 one-cycle completion / out-of-range pulses
//   rdata                          read result, valid with the granted ack
//   mem_addr, mem_wdata            memory address / write data (hold when idle)
//   mem_memwrite, mem_memread      memory strobes, only during ACCESS
//   mem_rdata                      memory read data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] rdata,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state_q, state_d;

  logic              gnt0, gnt1;
  logic              grant_en;
  logic              load_access;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_bad;

  logic              port_q;   // port that owns the current transaction
  logic              we_q;
  logic              err_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (p0_req),
    .req1   (p1_req),
    .update (grant_en),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // Winner's request fields; only meaningful when a grant is made.
  always_comb begin
    sel_we    = gnt1 ? p1_we    : p0_we;
    sel_addr  = gnt1 ? p1_addr  : p0_addr;
    sel_wdata = gnt1 ? p1_wdata : p0_wdata;
    addr_bad  = (sel_addr >= 32'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_en    = 1'b0;
    load_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant_en    = 1'b1;
          load_access = ~addr_bad;
          state_d     = addr_bad ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/wdata registers double as the memory-side outputs, so they are
  // loaded only for in-range grants and hold their value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (grant_en) begin
        port_q <= gnt1;
        we_q   <= sel_we;
        err_q  <= addr_bad;
      end
      if (load_access) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == ACCESS && !we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    mem_memwrite = (state_q == ACCESS) &  we_q;
    mem_memread  = (state_q == ACCESS) & ~we_q;
    rdata        = rdata_q;
    p0_ack       = (state_q == RESP) & ~err_q & ~port_q;
    p1_ack       = (state_q == RESP) & ~err_q &  port_q;
    p0_err       = (state_q == RESP) &  err_q & ~port_q;
    p1_err       = (state_q == RESP) &  err_q &  port_q;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter DEPTH, default 256, memory depth in words; legal word addresses are 0..DEPTH-1.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Ports p0_req / p1_req, input, 1 each: access request from port 0 (pipeline MEM stage) and port 1 (loader/debug).
REQ-006 Ports p0_we / p1_we, input, 1 each: 1 = write, 0 = read.
REQ-007 Ports p0_addr / p1_addr, input, 32 each: word address.
REQ-008 Ports p0_wdata / p1_wdata, input, DATA_W each: write data.
REQ-009 Ports p0_ack / p1_ack, output, 1 each: one-cycle completion pulse.
REQ-010 Ports p0_err / p1_err, output, 1 each: one-cycle out-of-range pulse, asserted instead of ack.
REQ-011 Port rdata, output, DATA_W: read result; valid only in the cycle of the granted port's ack.
REQ-012 Ports mem_addr (32), mem_wdata (DATA_W), mem_memwrite (1), mem_memread (1), outputs: drive the data memory.
REQ-013 Port mem_rdata, input, DATA_W: memory read data.

Function
REQ-014 FSM states: IDLE, ACCESS, RESP; registered state; reset state IDLE.
REQ-015 IDLE: if any request is asserted, select a winner, latch its we/addr/wdata into holding registers, go to ACCESS; otherwise stay in IDLE.
REQ-016 Arbitration: round-robin on the last_grant flag. With both requests asserted, grant the port not granted last; with one request asserted, grant it; after reset, port 0 wins a tie.
REQ-017 last_grant updates only when a grant is made in IDLE.
REQ-018 Address check in IDLE: an address >= DEPTH goes directly to RESP with the error flag set and no memory access.
REQ-019 ACCESS lasts exactly one cycle. mem_addr and mem_wdata are driven from the holding registers; mem_memwrite = we; mem_memread = !we. rdata captures mem_rdata at the end of ACCESS. Next state is RESP.
REQ-020 Outside ACCESS, mem_memwrite and mem_memread are 0, and mem_addr and mem_wdata hold their last values.
REQ-021 RESP lasts one cycle: pulse the granted port's ack (or err), hold rdata, return to IDLE.
REQ-022 Latency: request sampled in cycle N gives ack in cycle N+2; back-to-back service of the same port gives one access every 3 cycles.
REQ-023 A requester holds req, we, addr and wdata stable until its ack or err. req is sampled only in IDLE, and changes during ACCESS or RESP are ignored.
REQ-024 If req is still high in the IDLE cycle after ack, that is a new request.
REQ-025 ack and err never assert together or for both ports at once.
REQ-026 On a write, rdata is unchanged from its previous value.

Reset
REQ-027 rst_n low forces, immediately and asynchronously: state IDLE, last_grant = port 1 (so port 0 wins the first tie), all ack and err outputs 0, mem_memwrite and mem_memread 0, mem_addr, mem_wdata and rdata 0.
REQ-028 Reset during ACCESS aborts the access with no ack; the requester must re-request after reset.
REQ-029 Reset deassertion takes effect at the next rising clk edge; the first grant is possible in that cycle.

Structure
REQ-030 The shared package holds the FSM state encoding (IDLE=0, ACCESS=1, RESP=2, 2 bits) and the DEPTH default.
REQ-031 One sub-module, rr_arb2: a 2-input round-robin grant function (combinational grant plus the last_grant register), instantiated once.
REQ-032 The data memory is instantiated outside this block; this block only drives its ports.

Verification
REQ-033 Single read: p0 reads addr 10 while memory holds 10 -> mem_memread=1 for exactly one cycle, p0_ack in cycle N+2, rdata=10.
REQ-034 Write then read: p1 writes 0xDEADBEEF to addr 20, then p1 reads 20 -> p1_ack twice, rdata=0xDEADBEEF on the second ack, mem_memwrite high for one cycle only.
REQ-035 Contention: p0 and p1 request together continuously after reset -> grant order p0, p1, p0, p1, acks spaced 3 cycles apart.
REQ-036 Out of range: p0 reads addr 256 -> p0_err in cycle N+1, no memread/memwrite pulse, no ack.
REQ-037 Reset mid-access: assert rst_n=0 during ACCESS of a p1 write -> all outputs 0 immediately, no p1_ack; after release, a p0 request is served normally.
